avm_burst_read_master: RTL and testbench
========================================

Name: avm_burst_read_master

Overview:
- Avalon-MM burst read master that fetches a contiguous block of words from the DDR SDRAM controller's local interface inside the Qsys system. It is the initiator side of the memory slave port.
- Buffers the returned beats in an internal FIFO and presents them as a valid/ready stream to the convolution datapath.
- Credit-based flow control: a burst is only requested when the FIFO is guaranteed to have room for all of it.

Parameters:
- DATA_W, 32, local data width in bits.
- ADDR_W, 25, byte address width.
- MAX_BURST, 8, largest burstcount issued; power of 2.
- FIFO_DEPTH, 32, FIFO entries; power of 2, >= 2*MAX_BURST.
- LEN_W, 20, width of word_count.

Ports:
- clock_source  in  1  sole clock
- global_reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a block read
- base_addr  in  ADDR_W  byte address, aligned to DATA_W/8
- word_count  in  LEN_W  number of DATA_W words to read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- avm_address  out  ADDR_W  burst start byte address
- avm_read  out  1  read request
- avm_burstcount  out  $clog2(MAX_BURST)+1  beats in the burst
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  returned beat
- avm_readdatavalid  in  1  beat valid
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready

Behaviour:
- Reset state:
  - All outputs 0; FSM in IDLE.
  - FIFO flushed; remaining and pending counters cleared.
  - Reset mid-transfer abandons the block. Beats arriving while pending==0 are dropped and never reach the FIFO.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On start with word_count>0: latch base_addr and word_count into remaining, then go to ISSUE. busy rises the next cycle.
  - On start with word_count==0: pulse done the next cycle, stay in IDLE, assert no avm_read.
  - start while busy is ignored.
- ISSUE:
  - Burst size is bc = min(MAX_BURST, remaining).
  - Credit: free = FIFO_DEPTH - fifo_count - pending. Assert avm_read only when free >= bc.
  - avm_address and avm_burstcount are registered. They stay stable, and avm_read stays high, while avm_waitrequest=1.
  - On acceptance (avm_read && !avm_waitrequest), in the same edge:
    - address += bc*(DATA_W/8)
    - remaining -= bc
    - pending += bc
    - avm_read drops unless the next burst is also credit-eligible (back-to-back issue is allowed).
  - When remaining reaches 0 on an acceptance, go to DRAIN.
- pending counter:
  - Decrements by 1 per avm_readdatavalid.
  - Acceptance and readdatavalid in the same cycle give a net change of bc-1.
- DRAIN: when pending==0 and the FIFO is empty, pulse done for one cycle, drop busy, return to IDLE.
- FIFO write: every avm_readdatavalid beat while pending>0. Overflow is impossible by credit; the bench asserts it never happens.
- Stream side:
  - st_valid = !empty.
  - A transfer occurs on st_valid && st_ready.
  - st_data is held stable while st_valid && !st_ready.
- Latency: a beat on avm_readdatavalid at cycle N appears on st_valid/st_data at cycle N+1.
- Simultaneous FIFO push and pop at full or empty is legal; the count is unchanged.
- Beat order is preserved exactly.
- Counter widths: pending and fifo_count are $clog2(FIFO_DEPTH)+1 bits. remaining is LEN_W bits.

Optional Feature:
- Macro: AVM_PERF_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt (32 bits): counts cycles with avm_read && avm_waitrequest.
  - Adds output credit_cnt (32 bits): counts cycles in ISSUE where free < bc.
  - Both counters clear on an accepted start and saturate at all-ones.
  - Both reset to 0.
- Without the macro: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package avm_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN);
  - BC_W and CNT_W localparam functions derived from MAX_BURST and FIFO_DEPTH;
  - BYTES_PER_WORD constant.
- Sub-module burst_fifo: synchronous single-clock FIFO with DATA_W width and FIFO_DEPTH depth. It has push, pop, dout, empty, full and count outputs, and uses the same async active-high reset.

Test Plan:
- Basic multi-burst read:
  - Stimulus: base_addr=0x100, word_count=20, waitrequest=0, st_ready=1, slave returns beats 2 cycles after acceptance.
  - Required: bursts 8/8/4 at 0x100/0x120/0x140; 20 beats out in order; exactly one done pulse; busy low afterwards.
- Slave stall:
  - Stimulus: waitrequest high 3 cycles on the first burst.
  - Required: address/burstcount/read stable for all 4 cycles; exactly one acceptance; no duplicate beats.
- Backpressure:
  - Stimulus: st_ready=0, word_count=100.
  - Required: exactly 4 bursts of 8 accepted (32 words); no further avm_read until st_ready=1; then the remaining 68 words complete in order.
- Zero length:
  - Stimulus: word_count=0.
  - Required: done pulse on the next cycle; avm_read never asserted; busy stays 0.
- Reset mid-transfer:
  - Stimulus: global_reset pulsed mid-transfer, followed by 3 stray readdatavalid beats.
  - Required: all outputs 0; stray beats dropped; a following start of 5 words yields exactly 5 correct beats.
- Start while busy:
  - Stimulus: start asserted during DRAIN.
  - Required: ignored; exactly one done pulse for the original block.

Source files
------------

// File: rtl/avm_pkg.sv
// Shared types and width helpers for the Avalon-MM burst read master.
package avm_pkg;

  // Master sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width of a burstcount able to hold MAX_BURST itself.
  function automatic int bc_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  // Width of an occupancy counter able to hold the full FIFO depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Byte stride of one data word.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // Stride for the default 32-bit local interface.
  localparam int BYTES_PER_WORD = bytes_per_word(32);

endpackage

// File: rtl/avm_burst_read_master_burst_fifo.sv
// Single-clock FIFO buffering returned read beats. Show-ahead: the head
// word is visible on dout whenever the FIFO is not empty.
module burst_fifo
  import avm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    empty,
  output logic                    full,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  // A pop on empty is ignored; a push at full is only taken alongside a pop.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // Output reads as zero while empty so stale storage never leaks out.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/avm_burst_read_master.sv
// Avalon-MM burst read master: reads a contiguous block of words, buffers
// the beats in a FIFO and streams them out with valid/ready. A burst is only
// requested when the FIFO has guaranteed room for every beat of it.
// Optional macro AVM_PERF_CNT_EN adds stall_cnt and credit_cnt outputs.
module avm_burst_read_master
  import avm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 25,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 20
) (
  input  logic                       clock_source,
  input  logic                       global_reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           word_count,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic [bc_w(MAX_BURST)-1:0] avm_burstcount,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic [DATA_W-1:0]          st_data,
  output logic                       st_valid,
  input  logic                       st_ready
`ifdef AVM_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                credit_cnt
`endif
);

  localparam int BC_W  = bc_w(MAX_BURST);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;
  localparam int BPW   = bytes_per_word(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;
  logic              accept;
  logic [OCC_W-1:0]  occ_next;
  logic [OCC_W-1:0]  free_next;
  logic              credit_ok;

  assign accept    = read_q && !avm_waitrequest;
  // Beats with nothing outstanding (e.g. after a reset) are discarded.
  assign fifo_push = avm_readdatavalid && (pending_q != '0);
  assign fifo_pop  = !fifo_empty && st_ready;

  burst_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_source),
    .rst   (global_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (avm_readdata),
    .dout  (st_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Next-state sequencing, counters and look-ahead credit for the read strobe.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pending_d   = pending_q + (accept ? CNT_W'(bc_q) : '0)
                            - (fifo_push ? CNT_W'(1) : '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            busy_d      = 1'b1;
            state_d     = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_d      = addr_q + ADDR_W'(BPW * int'(bc_q));
          remaining_d = remaining_q - LEN_W'(bc_q);
          if (remaining_d == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((pending_q == '0) && fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    bc_d = (remaining_d >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(remaining_d);
    // FIFO entries plus outstanding beats as they will stand after this edge;
    // a push moves a beat from outstanding to stored and so cancels out.
    occ_next  = OCC_W'(fifo_count) + OCC_W'(pending_q)
              + (accept ? OCC_W'(bc_q) : '0) - (fifo_pop ? OCC_W'(1) : '0);
    free_next = OCC_W'(FIFO_DEPTH) - occ_next;
    credit_ok = free_next >= OCC_W'(bc_d);
    read_d    = (read_q && avm_waitrequest)
             || ((state_d == ISSUE) && (remaining_d != '0) && credit_ok);
  end

  // State and datapath registers.
  always_ff @(posedge clock_source or posedge global_reset) begin
    if (global_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= '0;
      bc_q        <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      bc_q        <= bc_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_burstcount = bc_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign st_valid       = !fifo_empty;

`ifdef AVM_PERF_CNT_EN
  logic             start_acc;
  logic [OCC_W-1:0] free_now;
  logic [31:0]      stall_cnt_q;
  logic [31:0]      credit_cnt_q;

  assign start_acc = (state_q == IDLE) && start;
  assign free_now  = OCC_W'(FIFO_DEPTH) - OCC_W'(fifo_count) - OCC_W'(pending_q);

  // Saturating counts of slave stalls and credit-starved issue cycles.
  always_ff @(posedge clock_source or posedge global_reset) begin
    if (global_reset) begin
      stall_cnt_q  <= '0;
      credit_cnt_q <= '0;
    end else if (start_acc) begin
      stall_cnt_q  <= '0;
      credit_cnt_q <= '0;
    end else begin
      if (read_q && avm_waitrequest && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == ISSUE) && (free_now < OCC_W'(bc_q)) && (credit_cnt_q != '1))
        credit_cnt_q <= credit_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign credit_cnt = credit_cnt_q;
`endif

endmodule

// File: tb/tb_avm_burst_read_master.sv
// Directed bench for avm_burst_read_master: a vector table of block reads
// plus hand-written sequences for backpressure, zero length, reset and
// start-while-busy.
module tb_avm_burst_read_master;

  logic        clock_source = 1'b0;
  logic        global_reset = 1'b1;
  logic        start = 1'b0;
  logic [24:0] base_addr = '0;
  logic [19:0] word_count = '0;
  logic        busy, done, avm_read, st_valid;
  logic [24:0] avm_address;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] st_data;
  logic        st_ready = 1'b1;
`ifdef AVM_PERF_CNT_EN
  logic [31:0] stall_cnt, credit_cnt;
`endif

  avm_burst_read_master dut (
    .clock_source      (clock_source),
    .global_reset      (global_reset),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready)
`ifdef AVM_PERF_CNT_EN
    ,
    .stall_cnt         (stall_cnt),
    .credit_cnt        (credit_cnt)
`endif
  );

  always #5 clock_source = ~clock_source;

  int checks = 0;
  int errors = 0;

  int cyc = 0, bursts = 0, last_bc = 0, read_hi = 0, done_cnt = 0, beats_out = 0;
  int first_rdv = -1, first_valid = -1, issued_words = 0, blk_words = 0;
  int stall_left = 0, stray_left = 0, overflow_events = 0;
  logic [24:0] last_addr = '0, blk_base = '0, prev_addr = '0;
  logic [3:0]  prev_bc = '0;
  logic        prev_stalled = 1'b0, prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  typedef struct {int due; logic [31:0] data;} beat_t;
  beat_t       slave_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic [24:0] base;
    int          words;
    int          stall;
    int          exp_bursts;
    logic [24:0] exp_last_addr;
    int          exp_last_bc;
    int          exp_read_hi;
  } vec_t;

  function automatic logic [31:0] beat_word(input logic [31:0] a);
    return 32'h5A00_0000 | a;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave model and stream monitor, run just after each falling edge.
  always @(negedge clock_source) begin
    #1;
    cyc++;
    if (global_reset) begin
      slave_q.delete();
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      prev_stalled      = 1'b0;
      prev_hold         = 1'b0;
    end else begin
      if (prev_stalled) begin
        check("stall_read", longint'(avm_read), 1);
        check("stall_addr", longint'(avm_address), longint'(prev_addr));
        check("stall_bc", longint'(avm_burstcount), longint'(prev_bc));
      end
      if (prev_hold) begin
        check("hold_valid", longint'(st_valid), 1);
        check("hold_data", longint'(st_data), longint'(prev_data));
      end
      if (st_valid && first_valid < 0) first_valid = cyc;
      if (st_valid && st_ready) begin
        beats_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0h required=none", st_data);
        end else begin
          check("beat_data", longint'(st_data), longint'(exp_q.pop_front()));
        end
      end
      prev_hold = st_valid && !st_ready;
      prev_data = st_data;
      if (done) done_cnt++;
      if (avm_read) read_hi++;

      avm_waitrequest = avm_read && (stall_left > 0);
      if (avm_waitrequest) stall_left--;
      prev_stalled = avm_waitrequest;
      prev_addr    = avm_address;
      prev_bc      = avm_burstcount;

      if (avm_read && !avm_waitrequest) begin
        int rem, ebc;
        bursts++;
        last_addr = avm_address;
        last_bc   = int'(avm_burstcount);
        rem = blk_words - issued_words;
        ebc = (rem > 8) ? 8 : rem;
        check("burst_addr", longint'(avm_address), longint'(blk_base) + 4 * issued_words);
        check("burst_bc", longint'(avm_burstcount), longint'(ebc));
        issued_words += int'(avm_burstcount);
        for (int j = 0; j < int'(avm_burstcount); j++)
          slave_q.push_back('{cyc + 2, beat_word(32'(avm_address) + 32'(4 * j))});
      end

      if (stray_left > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_0000 | 32'(stray_left);
        stray_left--;
      end else if (slave_q.size() > 0 && slave_q[0].due <= cyc) begin
        beat_t b;
        b = slave_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = b.data;
        if (first_rdv < 0) first_rdv = cyc;
      end else begin
        avm_readdatavalid = 1'b0;
      end
    end
  end

  // FIFO must never be asked to take a beat it cannot hold.
  always @(negedge clock_source) begin
    #3;
    if (!global_reset && dut.fifo_full && dut.fifo_push && !dut.fifo_pop)
      overflow_events++;
  end

  task automatic start_block(input logic [24:0] base, input int words, input int stall);
    @(negedge clock_source);
    base_addr    = base;
    word_count   = 20'(words);
    start        = 1'b1;
    blk_base     = base;
    blk_words    = words;
    issued_words = 0;
    stall_left   = stall;
    first_rdv    = -1;
    first_valid  = -1;
    for (int i = 0; i < words; i++) exp_q.push_back(beat_word(32'(base) + 32'(4 * i)));
    @(negedge clock_source);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock_source);
      #2;
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, budget);
    end
  endtask

  task automatic wait_bursts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (bursts < target && n < budget) begin
      @(negedge clock_source);
      #2;
      n++;
    end
    if (bursts < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, bursts, target);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_read"}, longint'(avm_read), 0);
    check({tag, "_addr"}, longint'(avm_address), 0);
    check({tag, "_bc"}, longint'(avm_burstcount), 0);
    check({tag, "_st_valid"}, longint'(st_valid), 0);
    check({tag, "_st_data"}, longint'(st_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int d0, b0, r0, o0;
    vecs[0] = '{25'h100,  20, 0, 3, 25'h140,  4, 3};
    vecs[1] = '{25'h200,   8, 3, 1, 25'h200,  8, 4};
    vecs[2] = '{25'h000,   5, 0, 1, 25'h000,  5, 1};
    vecs[3] = '{25'h1000, 17, 0, 3, 25'h1040, 1, 3};
    vecs[4] = '{25'h040,   1, 0, 1, 25'h040,  1, 1};

    repeat (3) @(negedge clock_source);
    #2;
    check_idle_outputs("reset");
    @(negedge clock_source);
    global_reset = 1'b0;

    foreach (vecs[k]) begin
      d0 = done_cnt; b0 = bursts; r0 = read_hi; o0 = beats_out;
      start_block(vecs[k].base, vecs[k].words, vecs[k].stall);
      wait_done(300, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_busy_at_done", k), longint'(busy), 0);
      repeat (3) @(negedge clock_source);
      #2;
      check($sformatf("vec%0d_done_pulses", k), longint'(done_cnt - d0), 1);
      check($sformatf("vec%0d_bursts", k), longint'(bursts - b0), longint'(vecs[k].exp_bursts));
      check($sformatf("vec%0d_last_addr", k), longint'(last_addr), longint'(vecs[k].exp_last_addr));
      check($sformatf("vec%0d_last_bc", k), longint'(last_bc), longint'(vecs[k].exp_last_bc));
      check($sformatf("vec%0d_read_cycles", k), longint'(read_hi - r0), longint'(vecs[k].exp_read_hi));
      check($sformatf("vec%0d_beats", k), longint'(beats_out - o0), longint'(vecs[k].words));
      check($sformatf("vec%0d_exp_left", k), longint'(exp_q.size()), 0);
      check($sformatf("vec%0d_latency", k), longint'(first_valid - first_rdv), 1);
    end

    // Backpressure: credit must cap issue at one FIFO's worth.
    d0 = done_cnt; b0 = bursts; r0 = read_hi; o0 = beats_out;
    st_ready = 1'b0;
    start_block(25'h000, 100, 0);
    repeat (60) @(negedge clock_source);
    #2;
    check("bp_bursts_stalled", longint'(bursts - b0), 4);
    check("bp_read_cycles", longint'(read_hi - r0), 4);
    check("bp_beats_stalled", longint'(beats_out - o0), 0);
    check("bp_st_valid", longint'(st_valid), 1);
    check("bp_busy", longint'(busy), 1);
    @(negedge clock_source);
    st_ready = 1'b1;
    wait_done(800, "bp");
    repeat (3) @(negedge clock_source);
    #2;
    check("bp_bursts_total", longint'(bursts - b0), 13);
    check("bp_beats_total", longint'(beats_out - o0), 100);
    check("bp_exp_left", longint'(exp_q.size()), 0);
    check("bp_done_pulses", longint'(done_cnt - d0), 1);

    // Zero length: immediate done, no read, busy never rises.
    d0 = done_cnt; r0 = read_hi;
    start_block(25'h080, 0, 0);
    #2;
    check("zero_done", longint'(done), 1);
    check("zero_busy", longint'(busy), 0);
    repeat (5) @(negedge clock_source);
    #2;
    check("zero_read_cycles", longint'(read_hi - r0), 0);
    check("zero_done_pulses", longint'(done_cnt - d0), 1);
    check("zero_busy_after", longint'(busy), 0);

    // Reset mid-transfer followed by stray beats, then a clean block.
    b0 = bursts;
    start_block(25'h300, 40, 0);
    wait_bursts(b0 + 2, 40, "rst_issue");
    @(negedge clock_source);
    global_reset = 1'b1;
    #2;
    check_idle_outputs("midrst");
    @(negedge clock_source);
    global_reset = 1'b0;
    exp_q.delete();
    stall_left = 0;
    stray_left = 3;
    o0 = beats_out;
    repeat (8) @(negedge clock_source);
    #2;
    check("stray_beats_out", longint'(beats_out - o0), 0);
    check("stray_st_valid", longint'(st_valid), 0);
    check("stray_busy", longint'(busy), 0);
    b0 = bursts; o0 = beats_out;
    start_block(25'h500, 5, 0);
    wait_done(100, "post_rst");
    repeat (2) @(negedge clock_source);
    #2;
    check("post_rst_beats", longint'(beats_out - o0), 5);
    check("post_rst_bursts", longint'(bursts - b0), 1);
    check("post_rst_last_bc", longint'(last_bc), 5);
    check("post_rst_exp_left", longint'(exp_q.size()), 0);

    // Start during DRAIN is ignored.
    d0 = done_cnt; b0 = bursts; r0 = read_hi; o0 = beats_out;
    start_block(25'h600, 8, 0);
    wait_bursts(b0 + 1, 20, "busy_issue");
    @(negedge clock_source);
    base_addr  = 25'h700;
    word_count = 20'd3;
    start      = 1'b1;
    #2;
    check("busy_during_drain", longint'(busy), 1);
    @(negedge clock_source);
    start = 1'b0;
    wait_done(100, "busy_blk");
    repeat (10) @(negedge clock_source);
    #2;
    check("busy_done_pulses", longint'(done_cnt - d0), 1);
    check("busy_bursts", longint'(bursts - b0), 1);
    check("busy_read_cycles", longint'(read_hi - r0), 1);
    check("busy_beats", longint'(beats_out - o0), 8);
    check("busy_exp_left", longint'(exp_q.size()), 0);
    check("busy_after", longint'(busy), 0);

    check("fifo_overflow_events", longint'(overflow_events), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
